// File: rtl/updown_counter_param_if.sv
// Bus bundle for updown_counter_param: count controls in, count and event flags out.
// Define UDC_MATCH_EN to add the cmp_val/match compare pair.
interface updown_counter_param_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 1
);
    logic              en;
    logic              ctl;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  out;
    logic              at_max;
    logic              at_min;
    logic              ovf;
    logic              udf;
`ifdef UDC_MATCH_EN
    logic [WIDTH-1:0]  cmp_val;
    logic              match;

    modport master (
        output en, ctl, load, load_val, step, cmp_val,
        input  out, at_max, at_min, ovf, udf, match
    );
    modport slave (
        input  en, ctl, load, load_val, step, cmp_val,
        output out, at_max, at_min, ovf, udf, match
    );
`else
    modport master (
        output en, ctl, load, load_val, step,
        input  out, at_max, at_min, ovf, udf
    );
    modport slave (
        input  en, ctl, load, load_val, step,
        output out, at_max, at_min, ovf, udf
    );
`endif
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, step, wrap/saturate and boundary event pulses.
// Define UDC_MATCH_EN to add a registered out==cmp_val match flag.
module updown_counter_param #(
    parameter int WIDTH  = 8,
    parameter int LIMIT  = 2**WIDTH - 1,
    parameter int STEP_W = 1,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    updown_counter_param_if.slave bus
);
    localparam logic [WIDTH:0]   LIMIT_X = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH:0]   MOD_X   = (WIDTH+1)'(LIMIT + 1);
    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    // One extra bit so the up-sum and the boundary compares cannot overflow.
    logic [WIDTH:0] out_x, step_x, load_x;
    logic [WIDTH:0] sum_x, diff_x, wrap_up_x, wrap_dn_x;

    assign out_x     = {1'b0, out_q};
    assign step_x    = (WIDTH+1)'(bus.step);
    assign load_x    = {1'b0, bus.load_val};
    assign sum_x     = out_x + step_x;
    assign diff_x    = out_x - step_x;
    assign wrap_up_x = sum_x - MOD_X;
    assign wrap_dn_x = out_x + MOD_X - step_x;

    always_comb begin
        out_d = out_q;
        ovf_d = 1'b0;
        udf_d = 1'b0;
        if (bus.load) begin
            out_d = (load_x > LIMIT_X) ? LIMIT_W : bus.load_val;
        end else if (bus.en) begin
            if (bus.ctl) begin
                if (sum_x > LIMIT_X) begin
                    ovf_d = 1'b1;
                    out_d = WRAP ? WIDTH'(wrap_up_x) : LIMIT_W;
                end else begin
                    out_d = WIDTH'(sum_x);
                end
            end else begin
                if (step_x > out_x) begin
                    udf_d = 1'b1;
                    out_d = WRAP ? WIDTH'(wrap_dn_x) : '0;
                end else begin
                    out_d = WIDTH'(diff_x);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign bus.out    = out_q;
    assign bus.ovf    = ovf_q;
    assign bus.udf    = udf_q;
    assign bus.at_max = (out_q == LIMIT_W);
    assign bus.at_min = (out_q == '0);

`ifdef UDC_MATCH_EN
    logic match_q;

    // Compare against the next count so match lines up with out in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= (out_d == bus.cmp_val);
        end
    end

    assign bus.match = match_q;
`endif
endmodule
